// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Holds the hazard FSM state enum, the forward-select encodings, the memory
// wait timeout and the operand forward-select helper.
package hazard_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [FWD_W-1:0]  FWD_REG     = 2'b00;
  localparam logic [FWD_W-1:0]  FWD_WB      = 2'b01;
  localparam logic [FWD_W-1:0]  FWD_MEM     = 2'b10;
  localparam logic [WAIT_W-1:0] MEM_TIMEOUT = 4'd15;
  // r15 reads the PC, never a forwarded result
  localparam logic [REG_W-1:0]  REG_PC      = 4'd15;

  // Operand source select: the younger M result wins over W.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] ra,
    input logic [REG_W-1:0] wa_m,
    input logic [REG_W-1:0] wa_w,
    input logic             we_m,
    input logic             we_w
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_REG;
    if (ra != REG_PC) begin
      if (we_m && (wa_m == ra)) begin
        sel = FWD_MEM;
      end else if (we_w && (wa_w == ra)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst (sync, active-high), inc (count this cycle), count.
module sat_counter16
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall,
// branch flush and a memory-wait FSM with timeout error.
// Ports: clk, rst (sync, active-high); RA1D/RA2D, RA1E/RA2E source regs;
// WA3E/WA3M/WA3W destination regs; RegWriteM/W, MemtoRegE, BranchTakenE,
// MemReqM/MemAckM; outputs ForwardAE/BE, StallF/D/E/M, FlushD/E/W, MemErr.
// Define HAZARD_PERF_CNT_EN to add the StallCnt/FlushCnt saturating counters.
module pipe_hazard_unit
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic [FWD_W-1:0] ForwardAE,
  output logic [FWD_W-1:0] ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              load_use;
  logic              mem_hold;

  // Forwarding is purely combinational and ignores reset.
  assign ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
  assign ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);

  assign load_use = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  // The ack cycle already runs as normal, so the hold drops with the ack.
  assign mem_hold = (state_q == MEM_WAIT) && !MemAckM;
  assign MemErr   = err_q;

  // State, wait counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next state and hazard outputs.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushW  = 1'b0;

    case (state_q)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          // Give up on the access and let the pipe run again.
          if (wait_d == MEM_TIMEOUT) begin
            state_d = RUN;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      // all stalls and flushes held low while in reset
    end else if (mem_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      // A taken branch kills the stalled instruction, so no stall is needed.
      StallF = load_use && !BranchTakenE;
      StallD = load_use && !BranchTakenE;
      FlushD = BranchTakenE;
      FlushE = BranchTakenE || load_use;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (FlushD || FlushE),
    .count (FlushCnt)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios followed by
// randomized cycles checked against a behavioural model.
module tb_pipe_hazard_unit;

  logic       clk;
  logic       rst;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemAckM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] StallCnt, FlushCnt;
`endif

  int n_cmp;
  int n_fail;

  pipe_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .BranchTakenE (BranchTakenE),
    .MemReqM      (MemReqM),
    .MemAckM      (MemAckM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .MemErr       (MemErr)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Inputs change just after the falling edge; outputs are read 1ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  function automatic logic [6:0] hz_vec();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic test_reset();
    tick();
    clear_inputs();
    rst = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; BranchTakenE = 1'b1;
    MemReqM = 1'b1; RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
    RegWriteW = 1'b1; WA3W = 4'd7; RA2E = 4'd7;
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0) begin
      n_fail++; $display("FAIL reset_hz got %b required 0000000", hz_vec());
    end
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1001) begin
      n_fail++; $display("FAIL reset_fwd got %b required 1001", {ForwardAE, ForwardBE});
    end
    tick();
    #1;
    n_cmp++;
    if (MemErr !== 1'b0) begin
      n_fail++; $display("FAIL reset_memerr got %b required 0", MemErr);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if ({StallCnt, FlushCnt} !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h/%h required 0/0", StallCnt, FlushCnt);
    end
`endif
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0) begin
      n_fail++; $display("FAIL reset_run got %b required 0000000", hz_vec());
    end
  endtask

  task automatic test_forwarding();
    tick();
    clear_inputs();
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
    #1;
    n_cmp++;
    if (ForwardAE !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem got %b required 10", ForwardAE);
    end
    RegWriteM = 1'b0; WA3M = 4'd0; RegWriteW = 1'b1; WA3W = 4'd3;
    #1;
    n_cmp++;
    if (ForwardAE !== 2'b01) begin
      n_fail++; $display("FAIL fwd_wb got %b required 01", ForwardAE);
    end
    RegWriteM = 1'b1; WA3M = 4'd9; RA2E = 4'd9; WA3W = 4'd9;
    #1;
    n_cmp++;
    if (ForwardBE !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem_priority got %b required 10", ForwardBE);
    end
    WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15;
    #1;
    n_cmp++;
    if (ForwardAE !== 2'b00) begin
      n_fail++; $display("FAIL fwd_r15 got %b required 00", ForwardAE);
    end
  endtask

  task automatic test_load_use();
    tick();
    clear_inputs();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b1100010) begin
      n_fail++; $display("FAIL load_use got %b required 1100010", hz_vec());
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0) begin
      n_fail++; $display("FAIL load_use_after got %b required 0000000", hz_vec());
    end
  endtask

  task automatic test_branch_priority();
    tick();
    clear_inputs();
    MemtoRegE = 1'b1; WA3E = 4'd6; RA1D = 4'd6; BranchTakenE = 1'b1;
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0000110) begin
      n_fail++; $display("FAIL branch_prio got %b required 0000110", hz_vec());
    end
  endtask

  task automatic test_mem_ack();
    tick();
    clear_inputs();
    MemReqM = 1'b1; MemAckM = 1'b1;
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0) begin
      n_fail++; $display("FAIL mem_same_cycle_ack got %b required 0000000", hz_vec());
    end
    tick();
    MemAckM = 1'b0;
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0) begin
      n_fail++; $display("FAIL mem_req_run got %b required 0000000", hz_vec());
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      BranchTakenE = (i == 2);
      MemtoRegE = (i == 2); WA3E = 4'd4; RA1D = 4'd4;
      #1;
      n_cmp++;
      if (hz_vec() !== 7'b1111001) begin
        n_fail++; $display("FAIL mem_wait_%0d got %b required 1111001", i, hz_vec());
      end
    end
    tick();
    clear_inputs();
    MemAckM = 1'b1;
    #1;
    n_cmp++;
    if (hz_vec() !== 7'b0) begin
      n_fail++; $display("FAIL mem_ack_drop got %b required 0000000", hz_vec());
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if ({hz_vec(), MemErr} !== 8'b0) begin
      n_fail++; $display("FAIL mem_after_ack got %b required 00000000", {hz_vec(), MemErr});
    end
  endtask

  task automatic test_mem_timeout();
    tick();
    clear_inputs();
    MemReqM = 1'b1;
    #1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      #1;
      n_cmp++;
      if (hz_vec() !== 7'b1111001) begin
        n_fail++; $display("FAIL timeout_wait_%0d got %b required 1111001", i, hz_vec());
      end
    end
    tick();
    MemReqM = 1'b0;
    #1;
    n_cmp++;
    if ({hz_vec(), MemErr} !== 8'b00000001) begin
      n_fail++; $display("FAIL timeout_release got %b required 00000001", {hz_vec(), MemErr});
    end
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_cmp++;
    if (MemErr !== 1'b1) begin
      n_fail++; $display("FAIL memerr_sticky got %b required 1", MemErr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (MemErr !== 1'b0) begin
      n_fail++; $display("FAIL memerr_cleared got %b required 0", MemErr);
    end
  endtask

  task automatic test_reset_in_wait();
    tick();
    clear_inputs();
    MemReqM = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #1;
    n_cmp++;
    if (StallF !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_pre got %b required 1", StallF);
    end
    rst = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 16; i++) tick();
    #1;
    n_cmp++;
    if ({hz_vec(), MemErr} !== 8'b0) begin
      n_fail++; $display("FAIL rst_wait_abandon got %b required 00000000", {hz_vec(), MemErr});
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    clear_inputs();
    MemtoRegE = 1'b1; WA3E = 4'd2; RA2D = 4'd2;
    tick();
    clear_inputs();
    tick();
    MemtoRegE = 1'b1; WA3E = 4'd8; RA1D = 4'd8;
    tick();
    clear_inputs();
    BranchTakenE = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if ({StallCnt, FlushCnt} !== {16'd2, 16'd3}) begin
      n_fail++; $display("FAIL perf_cnt got %0d/%0d required 2/3", StallCnt, FlushCnt);
    end
  endtask
`endif

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra, input logic [3:0] wam,
                                         input logic [3:0] waw, input logic wem,
                                         input logic wew);
    if (ra == 4'd15) return 2'b00;
    if (wem && wam == ra) return 2'b10;
    if (wew && waw == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_random();
    bit waiting;
    int waited;
    bit err;
    int scnt, fcnt;
    bit hold, lu;
    logic [6:0] exp_hz;
    logic [4:0] exp_fwd;
    waiting = 1'b0; waited = 0; err = 1'b0; scnt = 0; fcnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      rst = (cyc == 0) || ($urandom_range(0, 149) == 0);
      RA1D = rand_reg(); RA2D = rand_reg(); RA1E = rand_reg(); RA2E = rand_reg();
      WA3E = rand_reg(); WA3M = rand_reg(); WA3W = rand_reg();
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 1));
      BranchTakenE = ($urandom_range(0, 3) == 0);
      MemReqM = ($urandom_range(0, 3) == 0);
      MemAckM = (cyc < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      #1;
      lu = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
      hold = waiting && !MemAckM;
      if (rst) exp_hz = 7'b0;
      else if (hold) exp_hz = 7'b1111001;
      else exp_hz = {lu && !BranchTakenE, lu && !BranchTakenE, 2'b00,
                     BranchTakenE, BranchTakenE || lu, 1'b0};
      exp_fwd = {ref_fwd(RA1E, WA3M, WA3W, RegWriteM, RegWriteW),
                 ref_fwd(RA2E, WA3M, WA3W, RegWriteM, RegWriteW), err};
      n_cmp++;
      if ({hz_vec(), ForwardAE, ForwardBE, MemErr} !== {exp_hz, exp_fwd}) begin
        n_fail++;
        $display("FAIL random cyc %0d got %b required %b", cyc,
                 {hz_vec(), ForwardAE, ForwardBE, MemErr}, {exp_hz, exp_fwd});
      end
`ifdef HAZARD_PERF_CNT_EN
      if (cyc > 0) begin
        n_cmp++;
        if (StallCnt !== 16'(scnt) || FlushCnt !== 16'(fcnt)) begin
          n_fail++;
          $display("FAIL random_cnt cyc %0d got %0d/%0d required %0d/%0d",
                   cyc, StallCnt, FlushCnt, scnt, fcnt);
        end
      end
`endif
      // Model update for the coming clock edge.
      if (rst) begin
        waiting = 1'b0; waited = 0; err = 1'b0; scnt = 0; fcnt = 0;
      end else begin
        if (exp_hz[6] && scnt < 65535) scnt++;
        if ((exp_hz[2] || exp_hz[1]) && fcnt < 65535) fcnt++;
        if (!waiting) begin
          if (MemReqM && !MemAckM) begin
            waiting = 1'b1; waited = 0;
          end
        end else if (MemAckM) begin
          waiting = 1'b0;
        end else begin
          waited++;
          if (waited == 15) begin
            waiting = 1'b0; err = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mem_ack();
    test_mem_timeout();
    test_reset_in_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
